// File: rtl/snake_map_render_if.sv
// Pixel-stream, map-RAM and colour-output signals of the snake map renderer.
// master = video timing / RAM side, slave = the renderer itself.
interface snake_map_render_if;
    logic        frame_start;
    logic        pix_valid;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        ram_gnt;
    logic [3:0]  ram_rdata;
    logic        ram_rd_en;
    logic [7:0]  ram_addr;
    logic [11:0] rgb;
    logic        rgb_valid;

    modport master (
        output frame_start, pix_valid, pix_x, pix_y, ram_gnt, ram_rdata,
        input  ram_rd_en, ram_addr, rgb, rgb_valid
    );

    modport slave (
        input  frame_start, pix_valid, pix_x, pix_y, ram_gnt, ram_rdata,
        output ram_rd_en, ram_addr, rgb, rgb_valid
    );
endinterface

// File: rtl/snake_map_render.sv
// Snake map renderer: maps each visible pixel onto a 16x16 cell map window,
// fetches the cell code from a shared map RAM (with a one-entry cache) and
// turns it into a 12-bit colour.  Fixed three-cycle latency, no stalls:
//   S0 pixel register -> S1 read issue (combinational strobe) ->
//   S2 code select (RAM data / cache) -> S3 colour register.
module snake_map_render #(
    parameter int ORG_X      = 192,
    parameter int ORG_Y      = 112,
    parameter int CELL_SHIFT = 4
) (
    input  logic              clk,
    input  logic              rst,
    snake_map_render_if.slave bus
);

    localparam logic [9:0] ORG_X_V    = 10'(ORG_X);
    localparam logic [9:0] ORG_Y_V    = 10'(ORG_Y);
    localparam logic [9:0] WIN_V      = 10'(16 << CELL_SHIFT);
    localparam logic [3:0] CODE_EMPTY = 4'hE;

    // Where S2 gets the cell code from.
    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_RAM,
        SRC_CACHE,
        SRC_EMPTY
    } src_e;

    // Per-pixel state carried from S1 into S2/S3.
    typedef struct packed {
        logic in_win;
        logic wall;
        src_e src;
    } s1_t;

    logic [2:0]  vld_pipe;      // [0]=S0, [1]=S1, [2]=rgb_valid
    logic [9:0]  s0_x, s0_y;

    logic [9:0]  rx, ry;
    logic        in_win;
    logic [3:0]  cell_x, cell_y;
    logic [7:0]  cell_addr;
    logic        wall;
    logic        hit;
    logic        rd_en;

    // The tag half of the cache follows issued reads so a pixel right behind
    // a fetch of the same cell already hits; the code half fills in S2 when
    // the RAM data arrives, which is still before that pixel reaches S2.
    logic        tag_vld;
    logic [7:0]  tag_addr;
    logic [3:0]  code_q;

    s1_t         s1_d, s1_q;
    logic [3:0]  code;
    logic [4:0]  frame_cnt;
    logic [11:0] rgb_d, rgb_q;

    // Valid shift register and S0 pixel capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            s0_x     <= '0;
            s0_y     <= '0;
        end else begin
            vld_pipe <= {vld_pipe[1:0], bus.pix_valid};
            s0_x     <= bus.pix_x;
            s0_y     <= bus.pix_y;
        end
    end

    // S1: window test, cell address and read decision.
    always_comb begin
        rx        = s0_x - ORG_X_V;
        ry        = s0_y - ORG_Y_V;
        in_win    = (s0_x >= ORG_X_V) && (s0_y >= ORG_Y_V) && (rx < WIN_V) && (ry < WIN_V);
        cell_x    = rx[CELL_SHIFT +: 4];
        // map y grows upward, screen y grows downward
        cell_y    = 4'd15 - ry[CELL_SHIFT +: 4];
        cell_addr = {cell_x, cell_y};
        wall      = (cell_x == 4'd0) || (cell_x == 4'd15) || (cell_y == 4'd0) || (cell_y == 4'd15);
        hit       = tag_vld && (cell_addr == tag_addr);
        rd_en     = !rst && vld_pipe[0] && in_win && bus.ram_gnt && !hit;
    end

    // S1: pick the code source for S2.
    always_comb begin
        s1_d        = '0;
        s1_d.in_win = vld_pipe[0] && in_win;
        s1_d.wall   = wall;
        s1_d.src    = SRC_NONE;
        if (rd_en) begin
            s1_d.src = SRC_RAM;
        end else if (vld_pipe[0] && in_win) begin
            // hit, or no grant: fall back to whatever the cache holds
            s1_d.src = tag_vld ? SRC_CACHE : SRC_EMPTY;
        end
    end

    assign bus.ram_rd_en = rd_en;
    // tag_addr always equals the last issued address, so it doubles as the
    // held address when no read is strobed.
    assign bus.ram_addr  = rst ? 8'h00 : (rd_en ? cell_addr : tag_addr);

    // Cache tag: follows issued reads; frame_start invalidates and wins over
    // a read issued in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld  <= 1'b0;
            tag_addr <= '0;
        end else begin
            if (rd_en) begin
                tag_addr <= cell_addr;
            end
            if (bus.frame_start) begin
                tag_vld <= 1'b0;
            end else if (rd_en) begin
                tag_vld <= 1'b1;
            end
        end
    end

    // Frame counter, free-running 5-bit wrap; bit 4 drives the food blink.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (bus.frame_start) begin
            frame_cnt <= frame_cnt + 5'd1;
        end
    end

    // S1 -> S2 register.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
        end else begin
            s1_q <= s1_d;
        end
    end

    // S2: code select.
    always_comb begin
        code = CODE_EMPTY;
        case (s1_q.src)
            SRC_RAM:   code = bus.ram_rdata;
            SRC_CACHE: code = code_q;
            default:   code = CODE_EMPTY;
        endcase
    end

    // S2: cache data fill from the returning read.
    always_ff @(posedge clk) begin
        if (rst) begin
            code_q <= CODE_EMPTY;
        end else if (s1_q.src == SRC_RAM) begin
            code_q <= bus.ram_rdata;
        end
    end

    // S3: colour mapping, walls override the cell code.
    always_comb begin
        rgb_d = 12'h000;
        if (vld_pipe[1] && s1_q.in_win) begin
            if (s1_q.wall) begin
                rgb_d = 12'h888;
            end else if (code <= 4'h3) begin
                rgb_d = 12'h0F0;
            end else if (code <= 4'h7) begin
                rgb_d = 12'h0A0;
            end else if (code <= 4'hD) begin
                rgb_d = 12'h080;
            end else if (code == 4'hF && !frame_cnt[4]) begin
                rgb_d = 12'hF00;
            end
        end
    end

    // S3 colour register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign bus.rgb       = rgb_q;
    assign bus.rgb_valid = vld_pipe[2];

endmodule

// File: doc/snake_map_render.md
SNAKE_MAP_RENDER -- requirements
Module: snake_map_render

Interface
REQ-001 Parameter ORG_X, default 192: left pixel column of the 256x256 map window.
REQ-002 Parameter ORG_Y, default 112: top pixel row of the map window.
REQ-003 Parameter CELL_SHIFT, default 4: log2 of the cell edge in pixels; window edge = 16 << CELL_SHIFT.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 frame_start  in  1  one-cycle pulse at the start of each video frame.
REQ-007 pix_valid  in  1  pix_x/pix_y carry a visible pixel this cycle.
REQ-008 pix_x  in  10  pixel column.
REQ-009 pix_y  in  10  pixel row, 0 = top of screen.
REQ-010 ram_gnt  in  1  renderer owns the map RAM read port this cycle (low while the movement engine writes).
REQ-011 ram_rdata  in  4  map cell code; valid one cycle after ram_rd_en.
REQ-012 ram_rd_en  out  1  read strobe to the map RAM.
REQ-013 ram_addr  out  8  {cell_x[3:0], cell_y[3:0]}; cell_x is the high nibble.
REQ-014 rgb  out  12  {R4,G4,B4} pixel colour.
REQ-015 rgb_valid  out  1  rgb corresponds to a pix_valid input from 3 cycles earlier.

Function
REQ-016 Pipeline: stage S0 registers the pixel; S1 issues the read; S2 captures ram_rdata; S3 registers rgb. rgb_valid SHALL equal pix_valid delayed by exactly 3 cycles, with no stalls.
REQ-017 In-window test: rx = pix_x - ORG_X and ry = pix_y - ORG_Y are computed unsigned at 10 bits. The pixel is in the window when pix_x >= ORG_X, pix_y >= ORG_Y, rx < 16<<CELL_SHIFT and ry < 16<<CELL_SHIFT.
REQ-018 cell_x = rx >> CELL_SHIFT; cell_y = 15 - (ry >> CELL_SHIFT). Map y increases upward, so screen-top row 0 maps to cell_y 15.
REQ-019 Cache: hold the last fetched address and code, plus a cache-valid flag.
REQ-020 S1 asserts ram_rd_en with ram_addr only when all of the following hold: the pixel is valid, it is in the window, ram_gnt=1, and (the cache is invalid or the address differs from the cached address).
REQ-021 When ram_rd_en is asserted, S2 loads the cache with ram_rdata and the address, and sets cache-valid.
REQ-022 When no read is issued because of a cache hit, S2 uses the cached code.
REQ-023 When ram_gnt=0 on a cache miss, S2 uses the stale cached code and the next pixel retries.
REQ-024 When ram_gnt=0 and the cache is invalid, S2 uses code 4'hE.
REQ-025 Cache-valid SHALL clear on frame_start.
REQ-026 ram_rd_en SHALL never be asserted while ram_gnt=0; ram_addr holds its value when ram_rd_en=0.
REQ-027 Frame counter: 5 bits, increments on each frame_start, wraps from 31 to 0.
REQ-028 Colour mapping in S3, applied in priority order:
  - pixel not valid -> 12'h000
  - pixel outside the window -> 12'h000
  - cell_x or cell_y equal to 0 or 15 (wall) -> 12'h888, whatever the code
  - code 0-3 (head) -> 12'h0F0
  - code 4-7 (tail) -> 12'h0A0
  - code 8-D (body) -> 12'h080
  - code E (empty) -> 12'h000
  - code F (food) -> 12'hF00 when frame counter bit 4 = 0, else 12'h000
REQ-029 If frame_start and pix_valid occur in the same cycle, the counter update and cache clear take effect first; that pixel is treated as a cache miss.

Reset
REQ-030 While rst=1: all pipeline valid bits, cache-valid, frame counter, ram_rd_en, ram_addr, rgb and rgb_valid SHALL be 0.
REQ-031 rst asserted mid-frame discards all in-flight pixels; rgb_valid is 0 until 3 cycles after the first pix_valid following rst deassertion.

Verification
REQ-032 After reset, pix_valid=1 at (pix_x=200, pix_y=120), ram_gnt=1, ram_rdata=4'h1 -> ram_rd_en=1 with ram_addr=8'h0F; then, 3 cycles after the input, rgb=12'h888 (wall) with rgb_valid=1.
REQ-033 16 consecutive pixels at (pix_x=320..335, pix_y=240), ram_gnt=1, ram_rdata=4'hC -> exactly one ram_rd_en, address 8'h87; all 16 outputs are rgb=12'h080.
REQ-034 Cell (8,7) holds F; issue 16 frame_start pulses, then the pixel at (pix_x=320, pix_y=240) -> rgb=12'h000; after 16 more frame_start pulses the same pixel gives rgb=12'hF00.
REQ-035 Cache holds addr 8'h87 with code E; ram_gnt=0 and the pixel at (pix_x=336, pix_y=240), cell 8'h97 -> no ram_rd_en and rgb=12'h000; the same pixel with ram_gnt=1 -> read of 8'h97 is issued.
REQ-036 pix_valid at (pix_x=10, pix_y=10) -> no ram_rd_en and rgb=12'h000 with rgb_valid=1; rst pulsed while 2 pixels are in flight -> rgb_valid stays 0 for those pixels.
